// File: rtl/systolic_feed_scheduler.sv
// Skewed per-row feed scheduler for a ROWS x COLS systolic array. Define
// SCHED_STALL_CNT_EN to add the 16-bit saturating stall_cycles counter output.
module systolic_feed_scheduler #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] tile_len,
  input  logic [ROWS-1:0]  stall_in,
  output logic [ROWS-1:0]  feed,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
`ifdef SCHED_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  // t must reach (2^LEN_W-1)+ROWS-2 without wrapping.
  localparam int T_W = LEN_W + $clog2(ROWS + 1);
  localparam int D_W = $clog2(COLS + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [LEN_W-1:0] len_q;
  logic [T_W-1:0]   t_q;
  logic [D_W-1:0]   dcnt_q;

  logic [T_W-1:0]   len_ext;
  logic [T_W-1:0]   last_t;
  logic [ROWS-1:0]  active;
  logic             stall;

  // Handshake: each row consumes one element in every cycle its feed bit is
  // high; stall_in[r] vetoes the whole step only while row r is active.
  always_comb begin
    len_ext = {{(T_W-LEN_W){1'b0}}, len_q};
    last_t  = len_ext + T_W'(ROWS) - T_W'(2);
    active  = '0;
    for (int r = 0; r < ROWS; r++) begin
      active[r] = (t_q >= T_W'(r)) && (t_q < T_W'(r) + len_ext);
    end
    stall = (state_q == FEED) && (|(active & stall_in));
    feed  = '0;
    if ((state_q == FEED) && !stall) begin
      feed = active;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      t_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (tile_len != '0) begin
              len_q   <= tile_len;
              t_q     <= '0;
              state_q <= FEED;
            end else begin
              state_q <= DONE;
            end
          end
        end
        FEED: begin
          if (!stall) begin
            if (t_q == last_t) begin
              dcnt_q  <= '0;
              state_q <= DRAIN;
            end else begin
              t_q <= t_q + T_W'(1);
            end
          end
        end
        DRAIN: begin
          // COLS+1 cycles: consumer read latency plus column propagation.
          if (dcnt_q == D_W'(COLS)) begin
            state_q <= DONE;
          end else begin
            dcnt_q <= dcnt_q + D_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

`ifdef SCHED_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
